spm_test_responder: RTL and testbench

Scratch-pad memory (SPM) responder for the pipeline CPU. It serves three access ports on one 32-bit word array:
- the test port driven by benches and the host loader;
- the CPU instruction-fetch port;
- the CPU MEM-stage data port.

The test port loads programs while the CPU is held (cpu_en=0) and reads results back afterwards. Accesses are arbitrated, reads are registered, and every test-port access is acknowledged.

---
 rtl/spm_test_responder.sv | 113 +++++++++++
 tb/tb_spm_test_responder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spm_test_responder.sv
// Scratch-pad memory responder: one 32-bit word array shared by the
// test/loader port, the CPU fetch port and the CPU MEM-stage data port.
module spm_test_responder #(
    parameter int          DEPTH_LOG2 = 12,
    parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_en,
    input  logic [29:0] test_spm_addr,
    input  logic        test_spm_as_,
    input  logic        test_spm_rw,
    input  logic [31:0] test_spm_wr_data,
    output logic [31:0] test_spm_rd_data,
    output logic        test_spm_ack,
    output logic        test_spm_busy,
    output logic        test_spm_err,
    output logic [15:0] test_wr_cnt,
    input  logic [29:0] if_spm_addr,
    input  logic        if_spm_as_,
    output logic [31:0] if_spm_rd_data,
    input  logic [29:0] mem_spm_addr,
    input  logic        mem_spm_as_,
    input  logic        mem_spm_rw,
    input  logic [31:0] mem_spm_wr_data,
    output logic [31:0] mem_spm_rd_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [31:0] spm [DEPTH];

    logic [DEPTH_LOG2-1:0] test_idx;
    logic [DEPTH_LOG2-1:0] if_idx;
    logic [DEPTH_LOG2-1:0] mem_idx;
    logic                  test_in_range;
    logic                  if_in_range;
    logic                  mem_in_range;
    logic                  test_req;
    logic                  test_grant;
    logic                  mem_active;
    logic                  mem_wr_en;
    logic                  test_wr_en;

    assign test_idx      = test_spm_addr[DEPTH_LOG2-1:0];
    assign if_idx        = if_spm_addr[DEPTH_LOG2-1:0];
    assign mem_idx       = mem_spm_addr[DEPTH_LOG2-1:0];
    assign test_in_range = ~|test_spm_addr[29:DEPTH_LOG2];
    assign if_in_range   = ~|if_spm_addr[29:DEPTH_LOG2];
    assign mem_in_range  = ~|mem_spm_addr[29:DEPTH_LOG2];

    // The MEM stage wins; the test port only gets the array when the
    // CPU is held or the MEM stage is idle, so the two never write together.
    assign mem_active    = cpu_en & ~mem_spm_as_;
    assign test_req      = ~test_spm_as_;
    assign test_grant    = test_req & (~cpu_en | mem_spm_as_);
    assign test_spm_busy = test_req & ~test_grant;

    assign mem_wr_en  = mem_active & ~mem_spm_rw & mem_in_range;
    assign test_wr_en = test_grant & ~test_spm_rw & test_in_range;

    // Array write port; contents survive reset and a write on a reset edge sticks.
    always_ff @(posedge clk) begin
        if (mem_wr_en) begin
            spm[mem_idx] <= mem_spm_wr_data;
        end else if (test_wr_en) begin
            spm[test_idx] <= test_spm_wr_data;
        end
    end

    // Test port: ack pulse, registered read data, sticky error, write counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            test_spm_ack     <= 1'b0;
            test_spm_rd_data <= 32'h0;
            test_spm_err     <= 1'b0;
            test_wr_cnt      <= 16'h0;
        end else begin
            test_spm_ack <= test_grant;
            if (test_grant) begin
                if (!test_in_range) begin
                    test_spm_err <= 1'b1;
                end
                if (test_spm_rw) begin
                    test_spm_rd_data <= test_in_range ? spm[test_idx] : 32'h0;
                end else if (test_wr_cnt != 16'hFFFF) begin
                    test_wr_cnt <= test_wr_cnt + 16'd1;
                end
            end
        end
    end

    // Fetch port: feed NOPs while the CPU is held, else registered array read.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_spm_rd_data <= 32'h0;
        end else if (!cpu_en) begin
            if_spm_rd_data <= NOP_INSN;
        end else if (!if_spm_as_) begin
            if_spm_rd_data <= if_in_range ? spm[if_idx] : 32'h0;
        end
    end

    // MEM-stage read data, held between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_spm_rd_data <= 32'h0;
        end else if (mem_active && mem_spm_rw) begin
            mem_spm_rd_data <= mem_in_range ? spm[mem_idx] : 32'h0;
        end
    end

endmodule

// File: tb/tb_spm_test_responder.sv
// Self-checking bench for spm_test_responder: directed scenarios plus
// randomized traffic scored against a word-array reference model.
module tb_spm_test_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          WORDS = 4096;

    logic        clk;
    logic        reset;
    logic        cpu_en;
    logic [29:0] test_spm_addr;
    logic        test_spm_as_;
    logic        test_spm_rw;
    logic [31:0] test_spm_wr_data;
    logic [31:0] test_spm_rd_data;
    logic        test_spm_ack;
    logic        test_spm_busy;
    logic        test_spm_err;
    logic [15:0] test_wr_cnt;
    logic [29:0] if_spm_addr;
    logic        if_spm_as_;
    logic [31:0] if_spm_rd_data;
    logic [29:0] mem_spm_addr;
    logic        mem_spm_as_;
    logic        mem_spm_rw;
    logic [31:0] mem_spm_wr_data;
    logic [31:0] mem_spm_rd_data;

    spm_test_responder #(.DEPTH_LOG2(12), .NOP_INSN(NOP)) dut (
        .clk              (clk),
        .reset            (reset),
        .cpu_en           (cpu_en),
        .test_spm_addr    (test_spm_addr),
        .test_spm_as_     (test_spm_as_),
        .test_spm_rw      (test_spm_rw),
        .test_spm_wr_data (test_spm_wr_data),
        .test_spm_rd_data (test_spm_rd_data),
        .test_spm_ack     (test_spm_ack),
        .test_spm_busy    (test_spm_busy),
        .test_spm_err     (test_spm_err),
        .test_wr_cnt      (test_wr_cnt),
        .if_spm_addr      (if_spm_addr),
        .if_spm_as_       (if_spm_as_),
        .if_spm_rd_data   (if_spm_rd_data),
        .mem_spm_addr     (mem_spm_addr),
        .mem_spm_as_      (mem_spm_as_),
        .mem_spm_rw       (mem_spm_rw),
        .mem_spm_wr_data  (mem_spm_wr_data),
        .mem_spm_rd_data  (mem_spm_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model state
    logic [31:0] ref_mem [WORDS];
    logic [31:0] e_trd;
    logic [31:0] e_if;
    logic [31:0] e_mrd;
    logic        e_ack;
    logic        e_err;
    int          e_cnt;
    bit          last_stall;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: predict from current inputs, advance, compare everything.
    task automatic tick();
        bit          req;
        bit          gnt;
        bit          mon;
        int unsigned ta;
        int unsigned fa;
        int unsigned ma;
        #1;
        req = (test_spm_as_ == 1'b0);
        mon = cpu_en && !mem_spm_as_;
        gnt = req && (!cpu_en || mem_spm_as_);
        ta  = int'(test_spm_addr);
        fa  = int'(if_spm_addr);
        ma  = int'(mem_spm_addr);
        chk("busy", {31'h0, test_spm_busy}, {31'h0, req && !gnt});
        last_stall = req && !gnt;
        if (reset) begin
            e_ack = 1'b0;
            e_trd = 32'h0;
            e_err = 1'b0;
            e_cnt = 0;
            e_if  = 32'h0;
            e_mrd = 32'h0;
        end else begin
            e_ack = gnt;
            if (gnt) begin
                if (ta >= WORDS) e_err = 1'b1;
                if (test_spm_rw)
                    e_trd = (ta < WORDS) ? ref_mem[ta] : 32'h0;
                else if (e_cnt < 65535)
                    e_cnt = e_cnt + 1;
            end
            if (!cpu_en)
                e_if = NOP;
            else if (!if_spm_as_)
                e_if = (fa < WORDS) ? ref_mem[fa] : 32'h0;
            if (mon && mem_spm_rw)
                e_mrd = (ma < WORDS) ? ref_mem[ma] : 32'h0;
        end
        if (mon && !mem_spm_rw && ma < WORDS)
            ref_mem[ma] = mem_spm_wr_data;
        if (gnt && !test_spm_rw && ta < WORDS)
            ref_mem[ta] = test_spm_wr_data;
        @(posedge clk);
        #1;
        chk("ack", {31'h0, test_spm_ack}, {31'h0, e_ack});
        chk("test_rd", test_spm_rd_data, e_trd);
        chk("err", {31'h0, test_spm_err}, {31'h0, e_err});
        chk("wr_cnt", {16'h0, test_wr_cnt}, 32'(e_cnt));
        chk("if_rd", if_spm_rd_data, e_if);
        chk("mem_rd", mem_spm_rd_data, e_mrd);
    endtask

    task automatic test_idle();
        test_spm_as_ = 1'b1;
        test_spm_rw  = 1'b1;
    endtask

    task automatic test_wr(input logic [29:0] a, input logic [31:0] d);
        test_spm_as_     = 1'b0;
        test_spm_rw      = 1'b0;
        test_spm_addr    = a;
        test_spm_wr_data = d;
    endtask

    task automatic test_rd(input logic [29:0] a);
        test_spm_as_  = 1'b0;
        test_spm_rw   = 1'b1;
        test_spm_addr = a;
    endtask

    function automatic logic [29:0] r_addr();
        if ($urandom_range(0, 7) == 0)
            return 30'($urandom_range(1, 255) << 12) | 30'($urandom_range(0, 63));
        return 30'($urandom_range(0, 63));
    endfunction

    initial begin
        checks     = 0;
        failures   = 0;
        e_cnt      = 0;
        e_err      = 1'b0;
        e_ack      = 1'b0;
        e_trd      = 32'h0;
        e_if       = 32'h0;
        e_mrd      = 32'h0;
        last_stall = 1'b0;
        reset            = 1'b1;
        cpu_en           = 1'b0;
        test_spm_addr    = 30'h0;
        test_spm_as_     = 1'b1;
        test_spm_rw      = 1'b1;
        test_spm_wr_data = 32'h0;
        if_spm_addr      = 30'h0;
        if_spm_as_       = 1'b1;
        mem_spm_addr     = 30'h0;
        mem_spm_as_      = 1'b1;
        mem_spm_rw       = 1'b1;
        mem_spm_wr_data  = 32'h0;

        // Reset state
        tick();
        chk("rst_trd", test_spm_rd_data, 32'h0);
        chk("rst_if", if_spm_rd_data, 32'h0);
        chk("rst_cnt", {16'h0, test_wr_cnt}, 32'h0);
        reset = 1'b0;

        // Program load, back-to-back writes then readback
        test_wr(30'd0, 32'h0000_0093);
        tick();
        chk("ld_ack0", {31'h0, test_spm_ack}, 32'h1);
        test_wr(30'd1, 32'h0010_0093);
        tick();
        chk("ld_ack1", {31'h0, test_spm_ack}, 32'h1);
        chk("ld_cnt", {16'h0, test_wr_cnt}, 32'd2);
        test_rd(30'd1);
        tick();
        chk("ld_rdback", test_spm_rd_data, 32'h0010_0093);
        test_idle();

        // Fetch NOP while held, real word once released
        if_spm_as_  = 1'b0;
        if_spm_addr = 30'd0;
        tick();
        chk("if_nop", if_spm_rd_data, NOP);
        cpu_en = 1'b1;
        tick();
        chk("if_run", if_spm_rd_data, 32'h0000_0093);
        if_spm_as_ = 1'b1;

        // MEM write stalls a test read of the same word
        test_wr(30'd7, 32'hAAAA_AAAA);
        tick();
        mem_spm_as_     = 1'b0;
        mem_spm_rw      = 1'b0;
        mem_spm_addr    = 30'd5;
        mem_spm_wr_data = 32'hDEAD_BEEF;
        test_rd(30'd5);
        #1;
        chk("stall_busy", {31'h0, test_spm_busy}, 32'h1);
        tick();
        chk("stall_noack", {31'h0, test_spm_ack}, 32'h0);
        mem_spm_as_ = 1'b1;
        tick();
        chk("stall_rd", test_spm_rd_data, 32'hDEAD_BEEF);
        chk("stall_ack", {31'h0, test_spm_ack}, 32'h1);
        test_idle();

        // Read-first on MEM write vs fetch of the same word
        mem_spm_as_     = 1'b0;
        mem_spm_rw      = 1'b0;
        mem_spm_addr    = 30'd7;
        mem_spm_wr_data = 32'h1234_5678;
        if_spm_as_      = 1'b0;
        if_spm_addr     = 30'd7;
        tick();
        chk("rf_old", if_spm_rd_data, 32'hAAAA_AAAA);
        mem_spm_as_ = 1'b1;
        tick();
        chk("rf_new", if_spm_rd_data, 32'h1234_5678);
        if_spm_as_ = 1'b1;

        // Out-of-range test accesses
        cpu_en = 1'b0;
        test_wr(30'h0000_1000, 32'hFFFF_FFFF);
        tick();
        chk("oor_err", {31'h0, test_spm_err}, 32'h1);
        chk("oor_cnt", {16'h0, test_wr_cnt}, 32'd4);
        test_rd(30'h0000_1000);
        tick();
        chk("oor_rd", test_spm_rd_data, 32'h0);
        test_rd(30'd0);
        tick();
        chk("oor_addr0", test_spm_rd_data, 32'h0000_0093);
        chk("oor_sticky", {31'h0, test_spm_err}, 32'h1);
        test_idle();

        // Preload the random-traffic window
        for (int i = 0; i < 64; i++) begin
            test_wr(30'(i), $urandom);
            tick();
        end

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset           = ($urandom_range(0, 99) == 0);
            cpu_en          = ($urandom_range(0, 3) != 0);
            mem_spm_as_     = $urandom_range(0, 1) == 1;
            mem_spm_rw      = $urandom_range(0, 1) == 1;
            mem_spm_addr    = r_addr();
            mem_spm_wr_data = $urandom;
            if_spm_as_      = $urandom_range(0, 1) == 1;
            if_spm_addr     = r_addr();
            if (!last_stall) begin
                test_spm_as_     = $urandom_range(0, 2) == 0;
                test_spm_rw      = $urandom_range(0, 1) == 1;
                test_spm_addr    = r_addr();
                test_spm_wr_data = $urandom;
            end
            tick();
        end
        reset       = 1'b0;
        mem_spm_as_ = 1'b1;
        if_spm_as_  = 1'b1;

        // Counter saturation
        cpu_en = 1'b0;
        test_wr(30'd2, 32'h5555_0002);
        while (e_cnt < 65535) tick();
        chk("sat_full", {16'h0, test_wr_cnt}, 32'h0000_FFFF);
        tick();
        chk("sat_hold", {16'h0, test_wr_cnt}, 32'h0000_FFFF);

        // Reset during a read cancels its ack
        test_rd(30'd1);
        reset = 1'b1;
        tick();
        chk("rst_rd_ack", {31'h0, test_spm_ack}, 32'h0);
        chk("rst_rd_data", test_spm_rd_data, 32'h0);
        reset = 1'b0;
        test_idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
